// File: rtl/vga_pkg.sv
// Shared types and default geometry for the ball motion controller.
package vga_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_BALL_SIZE = 4;

  typedef enum logic {
    POS = 1'b0,
    NEG = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/ball_motion_ctrl_axis_step.sv
// One-axis position step with edge reflection and range clamp.
module axis_step
  import vga_pkg::*;
#(
  parameter int MAX = 636,
  parameter int W   = 10
) (
  input  logic [W-1:0] pos,
  input  dir_t         dir,
  input  logic [3:0]   speed,
  output logic [W-1:0] pos_nxt,
  output dir_t         dir_nxt,
  output logic         flip
);

  localparam logic [W:0] LIM  = (W+1)'(MAX);
  localparam logic [W:0] LIM2 = (W+1)'(2 * MAX);

  logic [W:0] sum;
  logic [W:0] ext;
  logic [W:0] refl;
  logic [W:0] rise;

  always_comb begin
    sum     = {1'b0, pos} + (W+1)'(speed);
    ext     = (W+1)'(speed);
    refl    = LIM2 - sum;
    rise    = ext - {1'b0, pos};
    pos_nxt = pos;
    dir_nxt = dir;
    flip    = 1'b0;
    if (dir == POS) begin
      if (sum > LIM) begin
        flip    = 1'b1;
        dir_nxt = NEG;
        // overshoot beyond a full span lands on the far edge
        pos_nxt = (sum > LIM2) ? '0 : W'(refl);
      end else begin
        pos_nxt = W'(sum);
      end
    end else begin
      if (ext > {1'b0, pos}) begin
        flip    = 1'b1;
        dir_nxt = POS;
        pos_nxt = (rise > LIM) ? W'(LIM) : W'(rise);
      end else begin
        pos_nxt = pos - W'(speed);
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball position update: IDLE -> CALC -> COMMIT with tick queueing.
module ball_motion_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int BALL_SIZE = DEF_BALL_SIZE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [3:0] speed_x,
  input  logic [3:0] speed_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       pos_valid,
  output logic       bounce,
  output logic [7:0] bounce_cnt
);

  localparam int MAX_X = H_ACTIVE - BALL_SIZE;
  localparam int MAX_Y = V_ACTIVE - BALL_SIZE;

  ctrl_state_t state;
  ctrl_state_t state_nxt;

  logic       pending;
  logic       go;
  logic       load;
  logic       commit;
  logic       busy;
  logic [3:0] spd_x;
  logic [3:0] spd_y;
  logic       frz;
  dir_t       dir_x;
  dir_t       dir_y;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  dir_t       dx_nxt;
  dir_t       dy_nxt;
  logic       flip_x;
  logic       flip_y;
  logic       hit;

  assign go  = frame_tick | pending;
  assign hit = ~frz & (flip_x | flip_y);

  axis_step #(.MAX(MAX_X), .W(10)) u_step_x (
    .pos     (ball_x),
    .dir     (dir_x),
    .speed   (spd_x),
    .pos_nxt (x_nxt),
    .dir_nxt (dx_nxt),
    .flip    (flip_x)
  );

  axis_step #(.MAX(MAX_Y), .W(10)) u_step_y (
    .pos     (ball_y),
    .dir     (dir_y),
    .speed   (spd_y),
    .pos_nxt (y_nxt),
    .dir_nxt (dy_nxt),
    .flip    (flip_y)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = CALC;
      CALC:    state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load   = (state == IDLE) && go;
    commit = (state == COMMIT);
    busy   = (state == CALC) || (state == COMMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending    <= 1'b0;
      spd_x      <= '0;
      spd_y      <= '0;
      frz        <= 1'b0;
      ball_x     <= 10'(MAX_X / 2);
      ball_y     <= 10'(MAX_Y / 2);
      dir_x      <= POS;
      dir_y      <= POS;
      pos_valid  <= 1'b0;
      bounce     <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      // a tick during an update is held once; later ones are dropped
      if (load)                   pending <= 1'b0;
      else if (busy & frame_tick) pending <= 1'b1;
      if (load) begin
        spd_x <= speed_x;
        spd_y <= speed_y;
        frz   <= pause;
      end
      pos_valid <= commit;
      bounce    <= commit & hit;
      if (commit && !frz) begin
        ball_x <= x_nxt;
        ball_y <= y_nxt;
        dir_x  <= dx_nxt;
        dir_y  <= dy_nxt;
      end
      if (commit && hit && bounce_cnt != 8'hFF)
        bounce_cnt <= bounce_cnt + 8'd1;
    end
  end

endmodule

// File: doc/ball_motion_ctrl.md
BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter BALL_SIZE, default 4, ball edge length in pixels.
REQ-004 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 frame_tick  input  1  one-clk pulse at start of vertical blanking.
REQ-007 pause  input  1  high freezes motion; frame ticks are still consumed.
REQ-008 speed_x  input  4  pixels per frame on the X axis, sampled on accepted tick.
REQ-009 speed_y  input  4  pixels per frame on the Y axis, sampled on accepted tick.
REQ-010 ball_x  output  10  ball left edge, range 0..H_ACTIVE-BALL_SIZE.
REQ-011 ball_y  output  10  ball top edge, range 0..V_ACTIVE-BALL_SIZE.
REQ-012 pos_valid  output  1  one-clk pulse when ball_x/ball_y hold a new frame position.
REQ-013 bounce  output  1  one-clk pulse, coincident with pos_valid, if any axis reflected.
REQ-014 bounce_cnt  output  8  saturating count of bounce pulses.

Function
REQ-015 FSM states SHALL be IDLE, CALC, COMMIT; reset state SHALL be IDLE.
REQ-016 IDLE: on frame_tick or pending=1 -> CALC, sampling speed_x/speed_y and pause, clearing pending.
REQ-017 CALC: compute next X and next Y positions and directions combinationally from registered state -> COMMIT in 1 clk.
REQ-018 COMMIT: register the positions/directions, pulse pos_valid (and bounce if applicable), then -> IDLE.
REQ-019 Latency: pos_valid SHALL assert exactly 3 clk after the accepted frame_tick (tick at cycle n, pos_valid at n+3).
REQ-020 A frame_tick arriving in CALC or COMMIT SHALL set a one-deep pending flag; further ticks while pending=1 SHALL be dropped.
REQ-021 Per axis with dir=+: if pos+speed > MAX, where MAX=ACTIVE-BALL_SIZE, then pos=MAX-(pos+speed-MAX) (reflection) and dir flips to -.
REQ-022 Per axis with dir=-: if speed > pos, then pos=speed-pos and dir flips to +; pos+speed==MAX or pos==speed SHALL NOT flip.
REQ-023 The reflected result SHALL be clamped to 0..MAX when speed exceeds MAX; adds SHALL use 11-bit intermediates, with no wrap.
REQ-024 Speed 0 on an axis SHALL leave that axis position and direction unchanged, with no bounce.
REQ-025 Simultaneous X and Y reflection (corner) SHALL flip both directions and produce one bounce pulse, incrementing bounce_cnt by 1.
REQ-026 bounce_cnt SHALL saturate at 255.
REQ-027 Sampled pause=1: positions unchanged, pos_valid still pulses, bounce=0.
REQ-028 Positions and directions SHALL change only in COMMIT.

Reset
REQ-029 While reset=0 at a clk edge: state=IDLE, pending=0, ball_x=(H_ACTIVE-BALL_SIZE)/2, ball_y=(V_ACTIVE-BALL_SIZE)/2.
REQ-030 Reset SHALL also set: dir_x=+, dir_y=+, pos_valid=0, bounce=0, bounce_cnt=0.
REQ-031 Reset asserted in CALC or COMMIT SHALL abort the update with no pos_valid pulse; a frame_tick during reset SHALL be ignored.

Structure
REQ-032 Package vga_pkg SHALL hold the H_ACTIVE/V_ACTIVE/BALL_SIZE defaults, the dir_t typedef (POS/NEG) and the ctrl_state_t enum.
REQ-033 Per-axis reflect/clamp arithmetic SHALL be a combinational sub-module axis_step (params MAX, width 10), instantiated twice.

Verification
REQ-034 Reset release, frame_tick at cycle 10 with speed 2/2 -> pos_valid at cycle 13 with ball_x=320, ball_y=240, bounce=0.
REQ-035 ball_x=634, dir_x=+, speed_x=5, MAX=636 -> ball_x=633, dir_x=-, bounce=1, bounce_cnt=1.
REQ-036 ball_x=3, ball_y=2, both dir=-, speed 3/5 -> ball_x=0 with no X flip, ball_y=3 with dir_y=+, a single bounce pulse.
REQ-037 Two frame_ticks 1 clk apart, then a third 1 clk later -> exactly two pos_valid pulses, 3 clk apart.
REQ-038 pause=1 on a tick -> pos_valid pulses with positions unchanged; reset=0 in CALC -> no pos_valid, positions return to centre.
REQ-039 300 forced corner bounces -> bounce_cnt holds at 255.
